// File: rtl/mult_seq_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// Master drives operands and result acceptance; slave is the multiplier.
interface mult_seq_if #(
    parameter int WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               sgn;
    logic               q_mode;
    logic               ovm;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               ovf;

    modport master (
        output in_valid,
        output op_a,
        output op_b,
        output sgn,
        output q_mode,
        output ovm,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  op_a,
        input  op_b,
        input  sgn,
        input  q_mode,
        input  ovm,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output ovf
    );
endinterface

// File: rtl/mult_seq.sv
// Radix-2 sequential shift-add multiplier, signed/unsigned/fractional,
// with saturating or wrapping fractional overflow handling.
module mult_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    mult_seq_if.slave  bus
);
    localparam int PW = 2 * WIDTH;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [PW-1:0]    SAT_P = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0]    SAT_N = {1'b1, {(PW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplr;
    logic [PW-1:0]    r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;
    logic             r_q;
    logic             r_ovm;
    logic             r_fovf;
    logic [PW-1:0]    r_result;
    logic             r_ovf;

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_fovf;
    logic [PW-1:0]    w_sum;
    logic [PW-1:0]    w_sgnd;
    logic [PW-1:0]    w_frac;
    logic [PW-1:0]    w_fin;

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.ovf       = r_ovf;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);

    assign w_a_neg = bus.sgn & bus.op_a[WIDTH-1];
    assign w_b_neg = bus.sgn & bus.op_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (WIDTH'(0) - bus.op_a) : bus.op_a;
    assign w_b_mag = w_b_neg ? (WIDTH'(0) - bus.op_b) : bus.op_b;

    // (-1) x (-1) in Q format is the only product that cannot be represented
    assign w_fovf = bus.sgn & bus.q_mode
                  & (bus.op_a == MIN_V)
                  & (bus.op_b == MIN_V);

    assign w_sum  = r_acc + (r_mplr[0] ? r_mcand : '0);
    assign w_sgnd = r_neg ? (PW'(0) - r_acc) : r_acc;
    assign w_frac = r_q ? {w_sgnd[PW-2:0], 1'b0} : w_sgnd;
    assign w_fin  = r_fovf ? (r_ovm ? SAT_P : SAT_N) : w_frac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Counter runs 0..WIDTH-1 for the bit steps; count WIDTH is the
    // finalise step that applies sign, Q shift and overflow handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_q      <= 1'b0;
            r_ovm    <= 1'b0;
            r_fovf   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplr  <= w_b_mag;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_q     <= bus.q_mode;
            r_ovm   <= bus.ovm;
            r_fovf  <= w_fovf;
        end else if (r_state == S_BUSY) begin
            if (r_cnt != LAST) begin
                r_acc   <= w_sum;
                r_mcand <= {r_mcand[PW-2:0], 1'b0};
                r_mplr  <= {1'b0, r_mplr[WIDTH-1:1]};
                r_cnt   <= r_cnt + CNT_W'(1);
            end else begin
                r_result <= w_fin;
                r_ovf    <= r_fovf;
            end
        end
    end
endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq at WIDTH=16: products, latency,
// fractional overflow, back-pressure and reset abort.
module tb_mult_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;

    int n_cmp  = 0;
    int n_fail = 0;

    mult_seq_if #(.WIDTH(W)) bus ();

    mult_seq #(
        .WIDTH(W),
        .CNT_W(5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a,
                            input logic [W-1:0] b,
                            input logic s,
                            input logic q,
                            input logic o,
                            input bit noise);
        @(negedge clk);
        bus.op_a     = a;
        bus.op_b     = b;
        bus.sgn      = s;
        bus.q_mode   = q;
        bus.ovm      = o;
        bus.in_valid = 1'b1;
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        check("in_ready_busy", 64'(bus.in_ready), 64'd0);
        bus.op_a     = ~a;
        bus.op_b     = b ^ 16'h5a5a;
        bus.sgn      = ~s;
        bus.q_mode   = ~q;
        bus.ovm      = ~o;
        bus.in_valid = noise;
    endtask

    task automatic wait_done(input string tag,
                             input logic [31:0] exp_res,
                             input logic exp_ovf,
                             input bit chk_res);
        int n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_lat"}, 64'(n), 64'd17);
        if (chk_res) begin
            check({tag, "_res"}, 64'(bus.result), 64'(exp_res));
            check({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
        end
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_rel_ov"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_rel_ir"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        logic [31:0] held;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.sgn       = 1'b0;
        bus.q_mode    = 1'b0;
        bus.ovm       = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        rst_n = 1'b1;

        start_op(16'hFFFD, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done("neg3x7", 32'hFFFF_FFEB, 1'b0, 1'b1);
        release_out("neg3x7");

        start_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done("umax", 32'hFFFE_0001, 1'b0, 1'b1);
        release_out("umax");

        start_op(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_done("qsat", 32'h7FFF_FFFF, 1'b1, 1'b1);
        release_out("qsat");

        start_op(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_done("qwrap", 32'h8000_0000, 1'b1, 1'b1);
        release_out("qwrap");

        start_op(16'h4000, 16'hC000, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_done("qhalf", 32'hE000_0000, 1'b0, 1'b1);
        release_out("qhalf");

        start_op(16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done("zero", 32'h0000_0000, 1'b0, 1'b1);
        release_out("zero");

        start_op(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_done("smin2", 32'h4000_0000, 1'b0, 1'b1);
        release_out("smin2");

        start_op(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_done("sminmax", 32'hC000_8000, 1'b0, 1'b1);
        release_out("sminmax");

        start_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done("u1234", 32'h0626_0060, 1'b0, 1'b1);
        release_out("u1234");

        start_op(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_done("qmax", 32'h7FFE_0002, 1'b0, 1'b1);
        release_out("qmax");

        start_op(16'hABCD, 16'h1357, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done("uq", 32'h0, 1'b0, 1'b0);
        release_out("uq");

        // back-pressure with ignored in_valid while DONE
        start_op(16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done("bp", 32'h0000_000F, 1'b0, 1'b1);
        held = bus.result;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.op_a     = 16'(i + 9);
            bus.op_b     = 16'h00FF;
            @(negedge clk);
            check("bp_hold_res", 64'(bus.result), 64'd15);
            check("bp_hold_ir", 64'(bus.in_ready), 64'd0);
            check("bp_hold_ov", 64'(bus.out_valid), 64'd1);
        end
        check("bp_held", 64'(held), 64'd15);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("bp_ir_same_cyc", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_ir_next", 64'(bus.in_ready), 64'd1);
        check("bp_ov_next", 64'(bus.out_valid), 64'd0);

        // reset abort in the middle of BUSY
        start_op(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ir", 64'(bus.in_ready), 64'd1);
        check("abort_ov", 64'(bus.out_valid), 64'd0);
        check("abort_res", 64'(bus.result), 64'd0);
        check("abort_ovf", 64'(bus.ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort_no_ov", 64'(seen), 64'd0);

        start_op(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done("post_abort", 32'h0003_0A08, 1'b0, 1'b1);
        release_out("post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand width; legal range 4..32.
REQ-002 Parameter CNT_W, default 5: iteration counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset; one clock, asynchronous and active-low.
REQ-005 in_valid  input  1  operand presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 op_a, op_b  input  WIDTH each  operands.
REQ-008 sgn  input  1  1 = two's-complement operands; 0 = unsigned.
REQ-009 q_mode  input  1  1 = fractional result (product shifted left by 1); legal only with sgn=1.
REQ-010 ovm  input  1  overflow mode: 1 = saturate, 0 = wrap.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  2*WIDTH  product.
REQ-014 ovf  output  1  per-result flag: fractional overflow occurred on this result.

Function
REQ-015 States: IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE->BUSY on in_valid&in_ready. Capture op_a, op_b, sgn, q_mode and ovm; later input changes SHALL NOT affect the result.
REQ-017 On capture, signed operands SHALL be converted to magnitudes (two's-complement negate when MSB=1). Result sign = sign_a XOR sign_b.
REQ-018 BUSY: radix-2 shift-add on the magnitudes, one multiplier bit per cycle, exactly WIDTH cycles, then BUSY->DONE.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH+1 cycles after the accepting edge.
REQ-020 On entry to DONE: negate the magnitude product if the result sign is 1. If q_mode=1, shift left by 1 and drop the top bit.
REQ-021 Fractional overflow occurs only when q_mode=1, sgn=1 and op_a = op_b = -2^(WIDTH-1). In that case ovf=1.
REQ-022 On fractional overflow with ovm=1: result = 2^(2W-1)-1 (0x7FFF_FFFF for W=16).
REQ-023 On fractional overflow with ovm=0: result = 2^(2W-1), the wrapped value (0x8000_0000 for W=16).
REQ-024 Non-fractional signed or unsigned products SHALL NOT overflow 2*WIDTH bits; ovf=0 for them.
REQ-025 result and ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 DONE->IDLE on out_ready=1. in_ready is asserted the following cycle; no same-cycle accept/deliver overlap.
REQ-027 in_valid in BUSY or DONE SHALL be ignored (no capture, no state change).
REQ-028 Zero operand SHALL still take the full WIDTH+1 latency (no early termination).
REQ-029 q_mode=1 with sgn=0: the result is undefined and the block SHALL NOT hang.

Reset
REQ-030 rst_n=0 asynchronously forces IDLE, in_ready=1, out_valid=0, result=0, ovf=0 and clears the counter and datapath registers.
REQ-031 Reset asserted mid-BUSY or in DONE SHALL abort the operation, with no residual out_valid after release.
REQ-032 After rst_n deasserts, the first accept is possible on the next rising edge.

Verification (W=16)
REQ-033 sgn=1, q=0: op_a=0xFFFD (-3), op_b=0x0007 -> after 17 cycles result=0xFFFF_FFEB, ovf=0.
REQ-034 sgn=0: op_a=op_b=0xFFFF -> result=0xFFFE_0001, ovf=0.
REQ-035 sgn=1, q=1, op_a=op_b=0x8000: ovm=1 -> result=0x7FFF_FFFF, ovf=1; ovm=0 -> result=0x8000_0000, ovf=1.
REQ-036 sgn=1, q=1: op_a=0x4000, op_b=0xC000 (0.5 x -0.5) -> result=0xE000_0000, ovf=0.
REQ-037 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0. A new in_valid during this time is ignored. After out_ready=1, in_ready rises one cycle later.
REQ-038 Reset abort: pulse rst_n low at BUSY cycle 8 -> outputs match REQ-030 immediately; the next transaction completes correctly.
